// File: rtl/ctu_cluster_cken_seq.sv
// CTU cluster clock-enable / reset sequencer: staggered cken power-on,
// delayed grst_l/gdbginit_l release, and reverse-staggered debug-init cycling.
module ctu_cluster_cken_seq #(
    parameter int NUM_CLUSTERS = 4,
    parameter int STAGGER      = 8,
    parameter int GRST_DLY     = 16,
    parameter int DBG_HOLD     = 32,
    parameter int CNT_W        = 6
) (
    input  logic                    gclk,
    input  logic                    arst_l,
    input  logic                    start,
    input  logic                    dbginit_req,
    input  logic [NUM_CLUSTERS-1:0] cken_mask,
    output logic [NUM_CLUSTERS-1:0] cluster_cken,
    output logic                    grst_l,
    output logic                    gdbginit_l,
    output logic                    ready
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CKEN_ON   = 3'd1;
    localparam logic [2:0] ST_GRST_WAIT = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_CKEN_OFF  = 3'd4;
    localparam logic [2:0] ST_DBG_WAIT  = 3'd5;

    // Reload values are one less than the delay: the step fires on the edge
    // where the counter is already zero.
    localparam logic [CNT_W-1:0] STAG_RLD = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0] GRST_RLD = CNT_W'(GRST_DLY - 1);
    localparam logic [CNT_W-1:0] DBG_RLD  = CNT_W'(DBG_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic [NUM_CLUSTERS-1:0] mask_q;

    logic [NUM_CLUSTERS-1:0] on_pend;
    logic [NUM_CLUSTERS-1:0] on_pick;
    logic [NUM_CLUSTERS-1:0] off_pick;
    logic                    on_last;
    logic                    off_last;
    logic                    on_found;
    logic                    off_found;

    // Next cluster to enable is the lowest populated one still off; next to
    // disable is the highest one still on.
    always_comb begin
        on_pend   = mask_q & ~cluster_cken;
        on_pick   = '0;
        off_pick  = '0;
        on_found  = 1'b0;
        off_found = 1'b0;
        for (int i = 0; i < NUM_CLUSTERS; i++) begin
            if (on_pend[i] && !on_found) begin
                on_pick[i] = 1'b1;
                on_found   = 1'b1;
            end
        end
        for (int i = NUM_CLUSTERS - 1; i >= 0; i--) begin
            if (cluster_cken[i] && !off_found) begin
                off_pick[i] = 1'b1;
                off_found   = 1'b1;
            end
        end
        on_last  = ((on_pend & ~on_pick) == '0);
        off_last = ((cluster_cken & ~off_pick) == '0);
    end

    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            mask_q       <= '0;
            cluster_cken <= '0;
            grst_l       <= 1'b0;
            gdbginit_l   <= 1'b0;
            ready        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mask_q <= cken_mask;
                        cnt    <= '0;
                        state  <= ST_CKEN_ON;
                    end
                end
                ST_CKEN_ON: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        cluster_cken <= cluster_cken | on_pick;
                        if (on_last) begin
                            cnt   <= GRST_RLD;
                            state <= ST_GRST_WAIT;
                        end else begin
                            cnt <= STAG_RLD;
                        end
                    end
                end
                ST_GRST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        grst_l     <= 1'b1;
                        gdbginit_l <= 1'b1;
                        ready      <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (dbginit_req) begin
                        cnt   <= '0;
                        state <= ST_CKEN_OFF;
                    end
                end
                ST_CKEN_OFF: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        gdbginit_l   <= 1'b0;
                        ready        <= 1'b0;
                        cluster_cken <= cluster_cken & ~off_pick;
                        if (off_last) begin
                            cnt   <= DBG_RLD;
                            state <= ST_DBG_WAIT;
                        end else begin
                            cnt <= STAG_RLD;
                        end
                    end
                end
                ST_DBG_WAIT: begin
                    // The hold expiry itself performs the first re-enable.
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        cluster_cken <= cluster_cken | on_pick;
                        if (on_last) begin
                            cnt   <= GRST_RLD;
                            state <= ST_GRST_WAIT;
                        end else begin
                            cnt   <= STAG_RLD;
                            state <= ST_CKEN_ON;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctu_cluster_cken_seq.sv
// Self-checking bench for ctu_cluster_cken_seq: directed vector table, async
// reset sequence and randomized scenarios against an event-time model.
module tb_ctu_cluster_cken_seq;

    localparam int N = 4;
    localparam int S = 8;
    localparam int G = 16;
    localparam int H = 32;

    logic         gclk;
    logic         arst_l;
    logic         start;
    logic         dbginit_req;
    logic [N-1:0] cken_mask;
    logic [N-1:0] cluster_cken;
    logic         grst_l;
    logic         gdbginit_l;
    logic         ready;

    int n_checks;
    int n_fail;

    int           m_rise1 [N];
    int           m_fall  [N];
    int           m_rise2 [N];
    int           m_rel1;
    int           m_f;
    int           m_rel2;
    int           m_d;
    logic [N-1:0] m_mask;
    int           noise_q [$];

    int meas_rel1;
    int meas_dbg_fall;
    int meas_rel2;

    typedef struct {
        logic [N-1:0] mask;
        int           dbg_edge;
        int           noise_edge;
        int           exp_rel1;
        int           exp_dbg_fall;
        int           exp_rel2;
    } vec_t;

    vec_t vecs [6];

    ctu_cluster_cken_seq #(
        .NUM_CLUSTERS(N),
        .STAGGER     (S),
        .GRST_DLY    (G),
        .DBG_HOLD    (H),
        .CNT_W       (6)
    ) dut (
        .gclk        (gclk),
        .arst_l      (arst_l),
        .start       (start),
        .dbginit_req (dbginit_req),
        .cken_mask   (cken_mask),
        .cluster_cken(cluster_cken),
        .grst_l      (grst_l),
        .gdbginit_l  (gdbginit_l),
        .ready       (ready)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    // Event times relative to the start edge (edge 0), derived from the
    // ordered list of populated clusters.
    task automatic compute_sched(input logic [N-1:0] mask, input int d);
        int idx [$];
        int n;
        idx = {};
        for (int c = 0; c < N; c++) begin
            m_rise1[c] = -1;
            m_fall[c]  = -1;
            m_rise2[c] = -1;
            if (mask[c]) idx.push_back(c);
        end
        n      = idx.size();
        m_mask = mask;
        m_d    = d;
        for (int i = 0; i < n; i++) m_rise1[idx[i]] = 1 + S * i;
        m_rel1 = ((n > 0) ? 1 + S * (n - 1) : 1) + G;
        if (d >= 0) begin
            for (int j = 0; j < n; j++) m_fall[idx[n-1-j]] = d + 1 + S * j;
            m_f = (n > 0) ? d + 1 + S * (n - 1) : d + 1;
            for (int i = 0; i < n; i++) m_rise2[idx[i]] = m_f + H + S * i;
            m_rel2 = ((n > 0) ? m_f + H + S * (n - 1) : m_f + H) + G;
        end else begin
            m_f    = -1;
            m_rel2 = -1;
        end
    endtask

    function automatic logic [N+2:0] model_out(input int t);
        logic [N-1:0] ck;
        logic         rel;
        logic         dbg;
        for (int c = 0; c < N; c++) begin
            ck[c] = m_mask[c] && (t >= m_rise1[c]) &&
                    !((m_d >= 0) && (t >= m_fall[c]) && (t < m_rise2[c]));
        end
        rel = (t >= m_rel1);
        dbg = (m_d >= 0) && (t >= m_d + 1) && (t < m_rel2);
        return {ck, rel, rel && !dbg, rel && !dbg};
    endfunction

    function automatic logic is_noise(input int t);
        foreach (noise_q[i]) if (noise_q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic applyStimulus(input logic s, input logic [N-1:0] m, input logic dq);
        start       = s;
        cken_mask   = m;
        dbginit_req = dq;
    endtask

    task automatic checkOutput(input string name, input int t, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s edge=%0d got=%0h expected=%0h", name, t, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({cluster_cken, grst_l, gdbginit_l, ready});
    endfunction

    task automatic do_reset();
        arst_l = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        repeat (2) @(posedge gclk);
        #1 checkOutput("reset_state", -1, outs(), 0);
        @(negedge gclk);
        arst_l = 1'b1;
        @(posedge gclk);
        #1 checkOutput("idle_after_reset", -1, outs(), 0);
    endtask

    // Called 1 time unit after a posedge with the DUT idle.
    task automatic run_case(input logic [N-1:0] mask, input int d, input int stop_edge,
                            input string tag);
        int last;
        compute_sched(mask, d);
        last          = ((d >= 0) ? m_rel2 : m_rel1) + 12;
        meas_rel1     = -1;
        meas_dbg_fall = -1;
        meas_rel2     = -1;
        applyStimulus(1'b1, mask, is_noise(0));
        for (int t = 0; t <= last; t++) begin
            @(posedge gclk);
            #1;
            checkOutput(tag, t, outs(), int'(model_out(t)));
            if (meas_rel1 < 0 && ready) meas_rel1 = t;
            else if (meas_rel1 >= 0 && meas_dbg_fall < 0 && !gdbginit_l) meas_dbg_fall = t;
            else if (meas_dbg_fall >= 0 && meas_rel2 < 0 && ready) meas_rel2 = t;
            if (t == stop_edge) return;
            applyStimulus(1'($urandom), N'($urandom), (t + 1 == d) || is_noise(t + 1));
        end
    endtask

    initial begin
        logic [N-1:0] rmask;
        int           rd;
        n_checks = 0;
        n_fail   = 0;
        arst_l   = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);

        vecs[0] = '{4'b1111, -1,  12, 41,  -1,  -1};
        vecs[1] = '{4'b1010, -1,  -1, 25,  -1,  -1};
        vecs[2] = '{4'b0000, -1,   0, 17,  -1,  -1};
        vecs[3] = '{4'b1111, 100, -1, 41, 101, 197};
        vecs[4] = '{4'b0000, 30,  31, 17,  31,  79};
        vecs[5] = '{4'b1000, 50,  -1, 17,  51,  99};

        foreach (vecs[v]) begin
            noise_q = {};
            if (vecs[v].noise_edge >= 0) noise_q.push_back(vecs[v].noise_edge);
            do_reset();
            run_case(vecs[v].mask, vecs[v].dbg_edge, -1, $sformatf("vec%0d", v));
            checkOutput($sformatf("vec%0d_release_edge", v), -1, meas_rel1, vecs[v].exp_rel1);
            if (vecs[v].exp_dbg_fall >= 0) begin
                checkOutput($sformatf("vec%0d_dbg_fall_edge", v), -1, meas_dbg_fall,
                            vecs[v].exp_dbg_fall);
                checkOutput($sformatf("vec%0d_dbg_release_edge", v), -1, meas_rel2,
                            vecs[v].exp_rel2);
            end
        end

        // Asynchronous reset in the middle of power-on, then idle, then restart.
        noise_q = {};
        do_reset();
        run_case(4'b1111, -1, 12, "pre_arst");
        #2 arst_l = 1'b0;
        applyStimulus(1'b0, 4'b1111, 1'b0);
        #1 checkOutput("arst_immediate", 12, outs(), 0);
        repeat (3) begin
            @(posedge gclk);
            #1 checkOutput("arst_held", -1, outs(), 0);
        end
        @(negedge gclk);
        arst_l = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge gclk);
            #1 checkOutput("idle_start_low", i, outs(), 0);
        end
        run_case(4'b1111, -1, -1, "restart");
        checkOutput("restart_release_edge", -1, meas_rel1, 41);

        for (int r = 0; r < 12; r++) begin
            do_reset();
            rmask = N'($urandom);
            compute_sched(rmask, -1);
            rd = ($urandom_range(0, 3) == 0) ? -1 : m_rel1 + 1 + int'($urandom_range(0, 40));
            compute_sched(rmask, rd);
            noise_q = {};
            noise_q.push_back(int'($urandom_range(0, 32'(m_rel1))));
            noise_q.push_back(int'($urandom_range(0, 32'(m_rel1))));
            if (rd >= 0) noise_q.push_back(int'($urandom_range(32'(rd + 1), 32'(m_rel2))));
            run_case(rmask, rd, -1, $sformatf("random%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
